// File: rtl/ks_seq.sv
// DES key-schedule sequencer: one C/D register stepped forward or backward,
// presenting one round key per valid/ready handshake.
module ks_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] keyIn,
    input  logic        keyReady,
    output logic        keyValid,
    output logic [1:48] roundKey,
    output logic [4:0]  roundNum,
    output logic        busy,
    output logic        done
);

    typedef enum logic {StIdle, StActive} state_t;

    // Permuted choice 1: source bit (1-based) of keyIn for each C/D bit.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // Permuted choice 2: source bit (1-based) of C/D for each round-key bit.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[i+1] = k[PC1[i]];
        end
        return r;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[i+1] = cd[PC2[i]];
        end
        return r;
    endfunction

    // True when round r uses a two-bit rotation.
    function automatic logic shift_two(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic two);
        return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic two);
        return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    function automatic logic [1:56] rotl56(input logic [1:56] cd, input logic two);
        return {rotl28(cd[1:28], two), rotl28(cd[29:56], two)};
    endfunction

    function automatic logic [1:56] rotr56(input logic [1:56] cd, input logic two);
        return {rotr28(cd[1:28], two), rotr28(cd[29:56], two)};
    endfunction

    state_t      state;
    logic [1:56] cd;
    logic        dir_dec;

    logic [1:56] load_cd;
    logic [1:56] step_cd;
    logic [4:0]  step_round;
    logic        last_round;

    // Round key is a pure permutation of the register, so it tracks keyValid.
    assign roundKey = pc2(cd);

    // Load value and per-handshake step, selected by the latched direction.
    always_comb begin
        load_cd    = decrypt ? pc1(keyIn) : rotl56(pc1(keyIn), 1'b0);
        last_round = dir_dec ? (roundNum == 5'd1) : (roundNum == 5'd16);
        if (dir_dec) begin
            step_round = roundNum - 5'd1;
            step_cd    = rotr56(cd, shift_two(roundNum));
        end else begin
            step_round = roundNum + 5'd1;
            step_cd    = rotl56(cd, shift_two(roundNum + 5'd1));
        end
    end

    // Sequencer FSM with registered outputs; done is a one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            cd       <= '0;
            dir_dec  <= 1'b0;
            roundNum <= 5'd0;
            keyValid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StActive;
                        cd       <= load_cd;
                        dir_dec  <= decrypt;
                        roundNum <= decrypt ? 5'd16 : 5'd1;
                        keyValid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StActive: begin
                    if (keyReady) begin
                        if (last_round) begin
                            state    <= StIdle;
                            cd       <= '0;
                            roundNum <= 5'd0;
                            keyValid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            cd       <= step_cd;
                            roundNum <= step_round;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ks_seq.sv
// Scoreboard bench for ks_seq: stimulus pushes expected keys, a monitor pops on handshakes.
module tb_ks_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        decrypt;
    logic [63:0] keyIn;
    logic        keyReady;
    logic        keyValid;
    logic [47:0] roundKey;
    logic [4:0]  roundNum;
    logic        busy;
    logic        done;

    ks_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .decrypt  (decrypt),
        .keyIn    (keyIn),
        .keyReady (keyReady),
        .keyValid (keyValid),
        .roundKey (roundKey),
        .roundNum (roundNum),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rn;
        logic [47:0] key;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] ktab [1:16];
    int          checks = 0;
    int          failures = 0;
    int          done_count = 0;

    localparam logic [63:0] KeyClassic = 64'h133457799BBCDFF1;
    localparam logic [63:0] KeyOnes    = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] KeyParity  = 64'h0101010101010101;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted key is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && keyValid && keyReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_key actual=%0d/%h required=none", roundNum, roundKey);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("round_num", {59'd0, roundNum}, {59'd0, e.rn});
                chk("round_key", {16'd0, roundKey}, {16'd0, e.key});
            end
        end
        if (!reset && done) done_count++;
    end

    task automatic push_classic(input logic dec);
        for (int i = 1; i <= 16; i++) begin
            int r;
            r = dec ? 17 - i : i;
            exp_q.push_back({5'(r), ktab[r]});
        end
    endtask

    task automatic push_const(input logic [47:0] k);
        for (int i = 1; i <= 16; i++) exp_q.push_back({5'(i), k});
    endtask

    task automatic pulse_start(input logic [63:0] k, input logic dec);
        start   = 1'b1;
        keyIn   = k;
        decrypt = dec;
        @(posedge clk);
        #1;
        start   = 1'b0;
        keyIn   = ~k;
        decrypt = ~dec;
        chk("start_latency", {56'd0, keyValid, busy, roundNum},
            {56'd0, 1'b1, 1'b1, (dec ? 5'd16 : 5'd1)});
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_round(input logic [4:0] r);
        int n;
        n = 0;
        while (roundNum != r && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_round", {59'd0, roundNum}, {59'd0, r});
    endtask

    function automatic logic [63:0] outs();
        return {8'd0, keyValid, busy, done, roundNum, roundKey};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e;
        int snap;
        ktab[1]  = 48'h1B02EFFC7072; ktab[2]  = 48'h79AED9DBC9E5;
        ktab[3]  = 48'h55FC8A42CF99; ktab[4]  = 48'h72ADD6DB351D;
        ktab[5]  = 48'h7CEC07EB53A8; ktab[6]  = 48'h63A53E507B2F;
        ktab[7]  = 48'hEC84B7F618BC; ktab[8]  = 48'hF78A3AC13BFB;
        ktab[9]  = 48'hE0DBEBEDE781; ktab[10] = 48'hB1F347BA464F;
        ktab[11] = 48'h215FD3DED386; ktab[12] = 48'h7571F59467E9;
        ktab[13] = 48'h97C5D1FABA41; ktab[14] = 48'h5F43B7F2E73A;
        ktab[15] = 48'hBF918D3D3F0A; ktab[16] = 48'hCB3D8B0E17F5;

        reset = 1'b1; start = 1'b0; decrypt = 1'b0; keyIn = '0; keyReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_outputs", outs(), 64'd0);
        end

        // Encrypt, then start decrypt in the done cycle.
        push_classic(1'b0);
        pulse_start(KeyClassic, 1'b0);
        wait_done(e);
        chk("enc_edges", 64'(e), 64'd16);
        chk("enc_drained", 64'(exp_q.size()), 64'd0);
        push_classic(1'b1);
        pulse_start(KeyClassic, 1'b1);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        wait_done(e);
        chk("dec_edges", 64'(e), 64'd16);
        chk("dec_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk("after_dec_idle", outs(), 64'd0);

        // Consumer stall at round 3.
        push_classic(1'b0);
        pulse_start(KeyClassic, 1'b0);
        wait_round(5'd3);
        keyReady = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_hold", outs(), {8'd0, 1'b1, 1'b1, 1'b0, 5'd3, ktab[3]});
        end
        keyReady = 1'b1;
        wait_done(e);
        chk("stall_edges", 64'(e), 64'd14);
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Start ignored mid-schedule, then abort by reset.
        push_classic(1'b0);
        pulse_start(KeyClassic, 1'b0);
        wait_round(5'd5);
        start = 1'b1; keyIn = KeyOnes; decrypt = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_ignored", outs(), {8'd0, 1'b1, 1'b1, 1'b0, 5'd6, ktab[6]});
        wait_round(5'd7);
        reset = 1'b1;
        #1;
        chk("async_reset", outs(), 64'd0);
        exp_q.delete();
        snap = done_count;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_idle", outs(), 64'd0);
        end
        chk("abort_no_done", 64'(done_count), 64'(snap));
        push_const(48'hFFFFFFFFFFFF);
        pulse_start(KeyOnes, 1'b0);
        chk("new_k1", {16'd0, roundKey}, 64'h0000FFFFFFFFFFFF);
        wait_done(e);
        chk("ones_edges", 64'(e), 64'd16);
        chk("ones_drained", 64'(exp_q.size()), 64'd0);

        // Parity-only key; start during the final handshake is ignored.
        @(posedge clk);
        #1;
        push_const(48'h0);
        pulse_start(KeyParity, 1'b0);
        wait_round(5'd16);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("final_done", {61'd0, keyValid, busy, done}, 64'd1);
        @(posedge clk);
        #1;
        chk("final_start_ignored", outs(), 64'd0);
        chk("parity_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ks_seq.md
KS_SEQ -- requirements
Module: ks_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request a new schedule; sampled only when idle.
REQ-004 decrypt  input  1  direction, sampled with start; 0 = K1..K16, 1 = K16..K1.
REQ-005 keyIn  input  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,..,64 ignored; sampled with start.
REQ-006 keyReady  input  1  consumer accepts the current roundKey when high with keyValid.
REQ-007 keyValid  output  1  roundKey/roundNum valid.
REQ-008 roundKey  output  [1:48]  PC-2 of the current C/D register.
REQ-009 roundNum  output  [4:0]  index (1..16) of the presented roundKey; 0 when idle.
REQ-010 busy  output  1  high from start acceptance until the last key is accepted.
REQ-011 done  output  1  one-cycle pulse after the final key is accepted.

Function
REQ-012 The block SHALL hold one 56-bit C/D register (C = bits 1..28, D = bits 29..56) and a 2-state FSM, IDLE and ACTIVE.
REQ-013 Shift schedule s(i) SHALL be 1 for i in {1,2,9,16}, otherwise 2; C and D each rotate independently within 28 bits.
REQ-014 In IDLE with start=1, the block SHALL load C/D and enter ACTIVE, with keyValid=1 and busy=1 from the next cycle (latency 1 clock).
REQ-015 Encrypt load: C/D <= rotl(PC-1(keyIn), 1), i.e. C1D1, with roundNum=1.
REQ-016 Decrypt load: C/D <= PC-1(keyIn), i.e. C16D16 = C0D0, with roundNum=16.
REQ-017 roundKey SHALL be combinational PC-2 of the register, with no extra latency relative to keyValid.
REQ-018 A handshake occurs when keyValid=1 and keyReady=1; with no handshake, C/D, roundNum and roundKey SHALL hold unchanged.
REQ-019 Encrypt handshake at round r<16: C/D <= rotl(C/D, s(r+1)), roundNum <= r+1.
REQ-020 Decrypt handshake at round r>1: C/D <= rotr(C/D, s(r)), roundNum <= r-1.
REQ-021 Handshake on the final key (encrypt r=16, decrypt r=1): next cycle keyValid=0, busy=0, roundNum=0, done=1 for exactly one cycle, FSM returns to IDLE.
REQ-022 C/D SHALL be cleared to zero on return to IDLE, so roundKey=0 whenever idle.
REQ-023 start SHALL be ignored while busy=1, including the final-handshake cycle; start in the done cycle SHALL be accepted.
REQ-024 With keyReady held high, 16 keys SHALL appear on 16 consecutive cycles.
REQ-025 Changes on keyIn or decrypt while busy SHALL have no effect.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, C/D=0, keyValid=0, busy=0, done=0, roundNum=0, roundKey=0, regardless of the clock.
REQ-027 Reset mid-operation SHALL abort the schedule with no done pulse; the first start after deassertion begins a fresh schedule.

Verification
REQ-028 Assert reset, then release with start=0 -> all outputs 0 and remain 0.
REQ-029 Encrypt with keyIn=133457799BBCDFF1 and keyReady=1 -> roundNum 1..16 on consecutive cycles; K1=1B02EFFC7072, K2=79AED9DBC9E5, K16=CB3D8B0E17F5; done one cycle after K16.
REQ-030 Decrypt with the same key -> first key roundNum=16, roundKey=CB3D8B0E17F5; last key roundNum=1, roundKey=1B02EFFC7072; sequence equals the encrypt sequence reversed.
REQ-031 Encrypt, keyReady low for 5 cycles while roundNum=3 -> roundKey and roundNum stable for all 5 cycles; remaining keys are unchanged versus REQ-029.
REQ-032 Pulse start with a different key during round 5 -> ignored, sequence unchanged. Then assert reset during round 7 -> outputs zero at once, no done pulse; a new start yields K1 of the new key.
REQ-033 keyIn=0101010101010101 (parity bits only) -> all 16 roundKeys equal 000000000000.
